// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-in, write-back and ALU-out bundle of the decode stage.
// master = fetch/write-back/ALU side, slave = the decode stage itself.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic            is_lui;
  logic            is_i_type;
  logic            is_illegal;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;

  modport master (
    output in_valid, in_instr,
    output wb_en, wb_rd, wb_data,
    output out_ready,
    input  in_ready, out_valid,
    input  is_lui, is_i_type, is_illegal,
    input  rd_addr, rs1_data, rs2_data, imm
  );

  modport slave (
    input  in_valid, in_instr,
    input  wb_en, wb_rd, wb_data,
    input  out_ready,
    output in_ready, out_valid,
    output is_lui, is_i_type, is_illegal,
    output rd_addr, rs1_data, rs2_data, imm
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: rv32i decode (LUI/ADDI) with 32x32 regfile and one output register.
// Ports: clk, rst (async high), dec (slave: in_*, wb_*, out_*, decoded fields).
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave dec
);

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic [XLEN-1:0] rf_q [NREGS];

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  assign opcode  = dec.in_instr[6:0];
  assign funct3  = dec.in_instr[14:12];
  assign rs1_idx = dec.in_instr[19:15];
  assign rs2_idx = dec.in_instr[24:20];

  logic wb_act;
  assign wb_act = dec.wb_en && (dec.wb_rd != 5'd0);

  logic            valid_q, valid_d;
  logic            lui_q, lui_d;
  logic            itype_q, itype_d;
  logic            ill_q, ill_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      rs1i_q, rs1i_d;
  logic [4:0]      rs2i_q, rs2i_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] imm_q, imm_d;

  logic accept;
  assign dec.in_ready = !valid_q || dec.out_ready;
  assign accept       = dec.in_valid && dec.in_ready;

  // Decode of the incoming word
  logic            dec_lui;
  logic            dec_addi;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_lui  = (opcode == OP_LUI);
    dec_addi = (opcode == OP_IMM) && (funct3 == 3'b000);
    dec_ill  = !(dec_lui || dec_addi);
    dec_imm  = '0;
    unique case (1'b1)
      dec_lui:
        dec_imm = {{(XLEN-20){1'b0}}, dec.in_instr[31:12]};
      dec_addi:
        dec_imm = {{(XLEN-12){dec.in_instr[31]}},
                   dec.in_instr[31:20]};
      default:
        dec_imm = '0;
    endcase
  end

  // Source reads; a same-edge write-back wins over the array
  logic [XLEN-1:0] rd1_val;
  logic [XLEN-1:0] rd2_val;

  always_comb begin
    rd1_val = rf_q[rs1_idx];
    if (rs1_idx == 5'd0)
      rd1_val = '0;
    else if (wb_act && dec.wb_rd == rs1_idx)
      rd1_val = dec.wb_data;
  end

  always_comb begin
    rd2_val = rf_q[rs2_idx];
    if (rs2_idx == 5'd0)
      rd2_val = '0;
    else if (wb_act && dec.wb_rd == rs2_idx)
      rd2_val = dec.wb_data;
  end

  // Output stage next state
  always_comb begin
    valid_d = valid_q;
    lui_d   = lui_q;
    itype_d = itype_q;
    ill_d   = ill_q;
    rd_d    = rd_q;
    rs1i_d  = rs1i_q;
    rs2i_d  = rs2i_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    unique case (1'b1)
      accept: begin
        valid_d = 1'b1;
        lui_d   = dec_lui;
        itype_d = dec_addi;
        ill_d   = dec_ill;
        rd_d    = dec.in_instr[11:7];
        rs1i_d  = rs1_idx;
        rs2i_d  = rs2_idx;
        rs1_d   = rd1_val;
        rs2_d   = rd2_val;
        imm_d   = dec_imm;
      end
      (!accept && valid_q && dec.out_ready): begin
        valid_d = 1'b0;
      end
      (valid_q && !dec.out_ready): begin
        // Stalled: keep held sources coherent with write-back
        if (wb_act && dec.wb_rd == rs1i_q)
          rs1_d = dec.wb_data;
        if (wb_act && dec.wb_rd == rs2i_q)
          rs2_d = dec.wb_data;
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      lui_q   <= 1'b0;
      itype_q <= 1'b0;
      ill_q   <= 1'b0;
      rd_q    <= '0;
      rs1i_q  <= '0;
      rs2i_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      lui_q   <= lui_d;
      itype_q <= itype_d;
      ill_q   <= ill_d;
      rd_q    <= rd_d;
      rs1i_q  <= rs1i_d;
      rs2i_q  <= rs2i_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
    end
  end

  // Register file; x0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        rf_q[i] <= '0;
    end else if (wb_act) begin
      rf_q[dec.wb_rd] <= dec.wb_data;
    end
  end

  assign dec.out_valid  = valid_q;
  assign dec.is_lui     = lui_q;
  assign dec.is_i_type  = itype_q;
  assign dec.is_illegal = ill_q;
  assign dec.rd_addr    = rd_q;
  assign dec.rs1_data   = rs1_q;
  assign dec.rs2_data   = rs2_q;
  assign dec.imm        = imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed + random stimulus, scoreboard against
// an architectural model of the decode stage.
module tb_decode_stage;

  logic clk;
  logic rst;

  decode_stage_if #(.XLEN(32)) dif ();

  decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .dec (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        lui;
    logic        it;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_rf [32];
  int          checks;
  int          failures;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    e     = '0;
    e.rd  = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    if (w[6:0] == 7'b0110111) begin
      e.lui = 1'b1;
      e.imm = w >> 12;
    end else if (w[6:0] == 7'b0010011 && w[14:12] == 3'd0) begin
      e.it  = 1'b1;
      e.imm = $signed(w) >>> 20;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Reference model: one-deep output slot plus architectural regfile
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end else begin
      logic held;
      logic acc;
      held = (q.size() != 0);
      acc  = dif.in_valid && (!held || dif.out_ready);
      if (held && dif.out_ready) void'(q.pop_front());
      if (acc) q.push_back(ref_decode(dif.in_instr));
      if (dif.wb_en && dif.wb_rd != 5'd0)
        m_rf[dif.wb_rd] = dif.wb_data;
    end
  end

  // Monitor: a held instruction always shows the current register values
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(dif.in_ready),
          32'((q.size() == 0) || dif.out_ready));
      chk("out_valid", 32'(dif.out_valid), 32'(q.size() != 0));
      if (dif.out_valid && q.size() != 0) begin
        exp_t e;
        e = q[0];
        chk("is_lui", 32'(dif.is_lui), 32'(e.lui));
        chk("is_i_type", 32'(dif.is_i_type), 32'(e.it));
        chk("is_illegal", 32'(dif.is_illegal), 32'(e.ill));
        chk("rd_addr", 32'(dif.rd_addr), 32'(e.rd));
        chk("imm", dif.imm, e.imm);
        chk("rs1_data", dif.rs1_data, m_rf[e.rs1]);
        chk("rs2_data", dif.rs2_data, m_rf[e.rs2]);
      end
    end
  end

  task automatic drive(input logic        v,
                       input logic [31:0] ins,
                       input logic        ordy,
                       input logic        we,
                       input logic [4:0]  wr,
                       input logic [31:0] wd);
    @(posedge clk);
    #1;
    dif.in_valid  = v;
    dif.in_instr  = ins;
    dif.out_ready = ordy;
    dif.wb_en     = we;
    dif.wb_rd     = wr;
    dif.wb_data   = wd;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rd;
    r1 = 5'($urandom % 8);
    r2 = 5'($urandom % 8);
    rd = 5'($urandom);
    w  = $urandom;
    case ($urandom % 4)
      0: w = {w[31:12], rd, 7'b0110111};
      1: w = {w[31:25], r2, r1, 3'b000, rd, 7'b0010011};
      2: w = {w[31:25], r2, r1, 3'(1 + $urandom % 7), rd, 7'b0010011};
      default: w = {w[31:25], r2, r1, w[14:7], 7'b0110011};
    endcase
    return w;
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(dif.out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(dif.in_ready), 32'd1);
    chk({tag, "_is_lui"}, 32'(dif.is_lui), 32'd0);
    chk({tag, "_is_i_type"}, 32'(dif.is_i_type), 32'd0);
    chk({tag, "_is_illegal"}, 32'(dif.is_illegal), 32'd0);
    chk({tag, "_rd_addr"}, 32'(dif.rd_addr), 32'd0);
    chk({tag, "_rs1_data"}, dif.rs1_data, 32'd0);
    chk({tag, "_rs2_data"}, dif.rs2_data, 32'd0);
    chk({tag, "_imm"}, dif.imm, 32'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    dif.in_valid  = 1'b0;
    dif.in_instr  = '0;
    dif.out_ready = 1'b0;
    dif.wb_en     = 1'b0;
    dif.wb_rd     = '0;
    dif.wb_data   = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // LUI x5,0x12345
    drive(1, 32'h123452B7, 1, 0, 0, 0);
    drive(1, 32'hFFF00093, 1, 0, 0, 0);
    @(negedge clk);
    chk("lui_valid", 32'(dif.out_valid), 32'd1);
    chk("lui_flag", 32'(dif.is_lui), 32'd1);
    chk("lui_imm", dif.imm, 32'h00012345);
    chk("lui_rd", 32'(dif.rd_addr), 32'd5);
    chk("lui_illegal", 32'(dif.is_illegal), 32'd0);

    // Bypass: ADDI x4,x3,1 with x3 written the same edge
    drive(1, 32'h00118213, 1, 1, 5'd3, 32'hDEADBEEF);
    @(negedge clk);
    chk("addi_flag", 32'(dif.is_i_type), 32'd1);
    chk("addi_imm", dif.imm, 32'hFFFFFFFF);
    chk("addi_rs1", dif.rs1_data, 32'd0);
    chk("addi_rd", 32'(dif.rd_addr), 32'd1);

    drive(1, 32'h00018293, 1, 0, 0, 0);
    @(negedge clk);
    chk("bypass_rs1", dif.rs1_data, 32'hDEADBEEF);
    chk("bypass_imm", dif.imm, 32'd1);

    drive(1, 32'h00118213, 1, 0, 0, 0);
    @(negedge clk);
    chk("follow_rs1", dif.rs1_data, 32'hDEADBEEF);

    // Stall refresh over three cycles
    drive(1, 32'h00000113, 0, 0, 0, 0);
    @(negedge clk);
    chk("stall1_in_ready", 32'(dif.in_ready), 32'd0);
    chk("stall1_rs1", dif.rs1_data, 32'hDEADBEEF);
    drive(1, 32'h00000113, 0, 1, 5'd3, 32'h00000055);
    @(negedge clk);
    chk("stall2_in_ready", 32'(dif.in_ready), 32'd0);
    drive(1, 32'h00000113, 0, 0, 0, 0);
    @(negedge clk);
    chk("stall3_in_ready", 32'(dif.in_ready), 32'd0);
    chk("stall3_rs1", dif.rs1_data, 32'h00000055);
    chk("stall3_imm", dif.imm, 32'd1);
    chk("stall3_rd", 32'(dif.rd_addr), 32'd4);
    chk("stall3_itype", 32'(dif.is_i_type), 32'd1);
    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("release_valid", 32'(dif.out_valid), 32'd1);
    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("drained_valid", 32'(dif.out_valid), 32'd0);
    chk("drained_hold_imm", dif.imm, 32'd1);

    // x0 protection
    drive(0, 0, 1, 1, 5'd0, 32'h00001234);
    drive(1, 32'h00000113, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("x0_valid", 32'(dif.out_valid), 32'd1);
    chk("x0_rs1", dif.rs1_data, 32'd0);

    // Illegal, then reset while stalled
    drive(1, 32'h00000033, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ill_flag", 32'(dif.is_illegal), 32'd1);
    chk("ill_lui", 32'(dif.is_lui), 32'd0);
    chk("ill_itype", 32'(dif.is_i_type), 32'd0);
    chk("ill_imm", dif.imm, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 32'h00018193, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("postrst_valid", 32'(dif.out_valid), 32'd1);
    chk("postrst_x3", dif.rs1_data, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 4) != 0, gen_instr(),
            ($urandom % 4) != 0, ($urandom % 2) == 1,
            5'($urandom % 8), $urandom);
    end
    repeat (3) drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
